// File: rtl/wb_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
package wb_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned NUM_REGS = 16;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

endpackage

// File: rtl/wb_rr_arb2.sv
// Two-requester round-robin arbiter: one-hot grant, pointer moves to the
// requester that was not granted after every grant.
module wb_rr_arb2
    import wb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    src_e ptr_q, ptr_d;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = (ptr_q == SRC_A) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt[0]) begin
            ptr_d = SRC_B;
        end else if (gnt[1]) begin
            ptr_d = SRC_A;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= SRC_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/wb_port_scheduler.sv
// Writeback scheduler: arbitrates ALU and LSU onto the single register-file
// write port through a registered stage, and tracks pending writes.
module wb_port_scheduler
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = wb_pkg::DATA_W,
    parameter int unsigned ADDR_W = wb_pkg::ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [ADDR_W-1:0]   a_rd,
    input  logic [DATA_W-1:0]   a_data,
    input  logic                b_valid,
    output logic                b_ready,
    input  logic [ADDR_W-1:0]   b_rd,
    input  logic [DATA_W-1:0]   b_data,
    input  logic                wb_stall,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic [ADDR_W-1:0]   rs1,
    input  logic [ADDR_W-1:0]   rs2,
    output logic                rs1_busy,
    output logic                rs2_busy,
    output logic                reg_write,
    output logic [ADDR_W-1:0]   rd,
    output logic [DATA_W-1:0]   rd_data,
    output logic [NUM_REGS-1:0] busy
);

    logic [1:0]          gnt;
    logic                xfer;
    logic [ADDR_W-1:0]   sel_rd;
    logic [DATA_W-1:0]   sel_data;

    logic                reg_write_q, reg_write_d;
    logic [ADDR_W-1:0]   rd_q, rd_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;

    // Holding en low during reset keeps both readies low.
    wb_rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({b_valid, a_valid}),
        .en  (!wb_stall && !rst),
        .gnt (gnt)
    );

    assign a_ready  = gnt[0];
    assign b_ready  = gnt[1];
    assign xfer     = |gnt;
    assign sel_rd   = gnt[1] ? b_rd : a_rd;
    assign sel_data = gnt[1] ? b_data : a_data;

    always_comb begin
        reg_write_d = xfer && (sel_rd != '0);
        rd_d        = rd_q;
        rd_data_d   = rd_data_q;
        if (xfer) begin
            rd_d      = sel_rd;
            rd_data_d = sel_data;
        end
    end

    // Clear applied before set so a same-cycle reissue keeps the bit.
    always_comb begin
        busy_d = busy_q;
        if (reg_write_q) begin
            busy_d[rd_q] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            rd_data_q   <= '0;
            busy_q      <= '0;
        end else begin
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            rd_data_q   <= rd_data_d;
            busy_q      <= busy_d;
        end
    end

    assign reg_write = reg_write_q;
    assign rd        = rd_q;
    assign rd_data   = rd_data_q;
    assign busy      = busy_q;
    assign rs1_busy  = busy_q[rs1];
    assign rs2_busy  = busy_q[rs2];

endmodule
